// File: rtl/return_address_stack.sv
// Return address stack for fetch-stage return prediction: calls push, returns pop,
// and branches snapshot {ptr, count, top} so recovery restores the stack exactly.
module return_address_stack #(
    parameter int ENTRY_NUM  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int PTR_WIDTH  = $clog2(ENTRY_NUM),
    parameter int CNT_WIDTH  = $clog2(ENTRY_NUM + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] pushAddr,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] popAddr,
    output logic                  popValid,
    input  logic                  recover,
    input  logic [PTR_WIDTH-1:0]  recoverPtr,
    input  logic [CNT_WIDTH-1:0]  recoverCount,
    input  logic [ADDR_WIDTH-1:0] recoverTopAddr,
    output logic [PTR_WIDTH-1:0]  ckptPtr,
    output logic [CNT_WIDTH-1:0]  ckptCount,
    output logic [ADDR_WIDTH-1:0] ckptTopAddr
);

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(ENTRY_NUM);

    logic [ADDR_WIDTH-1:0] entry_q [ENTRY_NUM];
    logic [ADDR_WIDTH-1:0] entry_d [ENTRY_NUM];
    logic [PTR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [PTR_WIDTH-1:0]  top_idx;
    logic [PTR_WIDTH-1:0]  rec_top_idx;

    // ptr names the next free slot, so the live top sits one below it (mod depth).
    assign top_idx     = ptr_q - PTR_WIDTH'(1);
    assign rec_top_idx = recoverPtr - PTR_WIDTH'(1);

    always_comb begin
        entry_d = entry_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (recover) begin
            ptr_d   = recoverPtr;
            count_d = recoverCount;
            if (recoverCount != '0) begin
                entry_d[rec_top_idx] = recoverTopAddr;
            end
        end else if (push && pop && (count_q != '0)) begin
            // Link-and-return replaces the top in place; depth is unchanged.
            entry_d[top_idx] = pushAddr;
        end else if (push) begin
            entry_d[ptr_q] = pushAddr;
            ptr_d          = ptr_q + PTR_WIDTH'(1);
            if (count_q != FULL_CNT) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end else if (pop && (count_q != '0)) begin
            ptr_d   = top_idx;
            count_d = count_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                entry_q[i] <= '0;
            end
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                entry_q[i] <= entry_d[i];
            end
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Every request is taken in the cycle it appears; there is no ready/backpressure.
    assign popAddr     = entry_q[top_idx];
    assign popValid    = (count_q != '0);
    assign ckptPtr     = ptr_q;
    assign ckptCount   = count_q;
    assign ckptTopAddr = entry_q[top_idx];

endmodule

// File: tb/tb_return_address_stack.sv
// Directed table-driven bench for return_address_stack (depth 4, 32-bit PCs),
// plus hand-written reset and combinational-isolation sequences.
module tb_return_address_stack;

    logic        clk;
    logic        rst_n;
    logic        push;
    logic [31:0] push_addr;
    logic        pop;
    logic [31:0] pop_addr;
    logic        pop_valid;
    logic        recover;
    logic [1:0]  recover_ptr;
    logic [2:0]  recover_count;
    logic [31:0] recover_top_addr;
    logic [1:0]  ckpt_ptr;
    logic [2:0]  ckpt_count;
    logic [31:0] ckpt_top_addr;

    int n_cmp = 0;
    int n_bad = 0;

    return_address_stack #(.ENTRY_NUM(4), .ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push           (push),
        .pushAddr       (push_addr),
        .pop            (pop),
        .popAddr        (pop_addr),
        .popValid       (pop_valid),
        .recover        (recover),
        .recoverPtr     (recover_ptr),
        .recoverCount   (recover_count),
        .recoverTopAddr (recover_top_addr),
        .ckptPtr        (ckpt_ptr),
        .ckptCount      (ckpt_count),
        .ckptTopAddr    (ckpt_top_addr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [31:0] push_addr;
        logic        pop;
        logic        rec;
        logic [1:0]  rec_ptr;
        logic [2:0]  rec_cnt;
        logic [31:0] rec_top;
        logic [31:0] exp_top;
        logic        exp_valid;
        logic [1:0]  exp_ptr;
        logic [2:0]  exp_cnt;
    } vec_t;

    localparam int NVEC = 34;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic pu, input logic [31:0] pa, input logic po,
                                input logic rc, input logic [1:0] rp, input logic [2:0] rn,
                                input logic [31:0] rt, input logic [31:0] et, input logic ev,
                                input logic [1:0] ep, input logic [2:0] en);
        vec_t v;
        v.push = pu; v.push_addr = pa; v.pop = po;
        v.rec = rc; v.rec_ptr = rp; v.rec_cnt = rn; v.rec_top = rt;
        v.exp_top = et; v.exp_valid = ev; v.exp_ptr = ep; v.exp_cnt = en;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_state(input int idx, input logic [31:0] et, input logic ev,
                               input logic [1:0] ep, input logic [2:0] en);
        check("popAddr", idx, pop_addr, et);
        check("popValid", idx, {31'd0, pop_valid}, {31'd0, ev});
        check("ckptPtr", idx, {30'd0, ckpt_ptr}, {30'd0, ep});
        check("ckptCount", idx, {29'd0, ckpt_count}, {29'd0, en});
        check("ckptTopAddr", idx, ckpt_top_addr, et);
    endtask

    // driver
    task automatic drive_idle();
        push = 1'b0; push_addr = '0; pop = 1'b0;
        recover = 1'b0; recover_ptr = '0; recover_count = '0; recover_top_addr = '0;
    endtask

    task automatic apply_vec(input vec_t v);
        push = v.push; push_addr = v.push_addr; pop = v.pop;
        recover = v.rec; recover_ptr = v.rec_ptr;
        recover_count = v.rec_cnt; recover_top_addr = v.rec_top;
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    initial begin
        //            push pa        pop rec rp rn rt          exp_top   v  ptr cnt
        // LIFO
        vecs[0]  = mk(1, 32'h100, 0, 0, 0, 0, 0,            32'h100, 1, 1, 1);
        vecs[1]  = mk(1, 32'h200, 0, 0, 0, 0, 0,            32'h200, 1, 2, 2);
        vecs[2]  = mk(1, 32'h300, 0, 0, 0, 0, 0,            32'h300, 1, 3, 3);
        vecs[3]  = mk(0, 0,       1, 0, 0, 0, 0,            32'h200, 1, 2, 2);
        vecs[4]  = mk(0, 0,       1, 0, 0, 0, 0,            32'h100, 1, 1, 1);
        vecs[5]  = mk(0, 0,       1, 0, 0, 0, 0,            32'h0,   0, 0, 0);
        // overflow wrap: five pushes into four slots
        vecs[6]  = mk(1, 32'h10,  0, 0, 0, 0, 0,            32'h10,  1, 1, 1);
        vecs[7]  = mk(1, 32'h20,  0, 0, 0, 0, 0,            32'h20,  1, 2, 2);
        vecs[8]  = mk(1, 32'h30,  0, 0, 0, 0, 0,            32'h30,  1, 3, 3);
        vecs[9]  = mk(1, 32'h40,  0, 0, 0, 0, 0,            32'h40,  1, 0, 4);
        vecs[10] = mk(1, 32'h50,  0, 0, 0, 0, 0,            32'h50,  1, 1, 4);
        vecs[11] = mk(0, 0,       1, 0, 0, 0, 0,            32'h40,  1, 0, 3);
        vecs[12] = mk(0, 0,       1, 0, 0, 0, 0,            32'h30,  1, 3, 2);
        vecs[13] = mk(0, 0,       1, 0, 0, 0, 0,            32'h20,  1, 2, 1);
        vecs[14] = mk(0, 0,       1, 0, 0, 0, 0,            32'h50,  0, 1, 0);
        // underflow ignored, then push
        vecs[15] = mk(0, 0,       1, 0, 0, 0, 0,            32'h50,  0, 1, 0);
        vecs[16] = mk(0, 0,       1, 0, 0, 0, 0,            32'h50,  0, 1, 0);
        vecs[17] = mk(0, 0,       1, 0, 0, 0, 0,            32'h50,  0, 1, 0);
        vecs[18] = mk(1, 32'h40,  0, 0, 0, 0, 0,            32'h40,  1, 2, 1);
        // simultaneous push+pop
        vecs[19] = mk(1, 32'h200, 0, 0, 0, 0, 0,            32'h200, 1, 3, 2);
        vecs[20] = mk(1, 32'h500, 1, 0, 0, 0, 0,            32'h500, 1, 3, 2);
        vecs[21] = mk(0, 0,       1, 0, 0, 0, 0,            32'h40,  1, 2, 1);
        vecs[22] = mk(0, 0,       1, 0, 0, 0, 0,            32'h50,  0, 1, 0);
        vecs[23] = mk(1, 32'h700, 1, 0, 0, 0, 0,            32'h700, 1, 2, 1);
        // recovery priority: checkpoint after vec 24 is (ptr 3, cnt 2, top 0x100)
        vecs[24] = mk(1, 32'h100, 0, 0, 0, 0, 0,            32'h100, 1, 3, 2);
        vecs[25] = mk(1, 32'h200, 0, 0, 0, 0, 0,            32'h200, 1, 0, 3);
        vecs[26] = mk(0, 0,       1, 0, 0, 0, 0,            32'h100, 1, 3, 2);
        vecs[27] = mk(1, 32'h900, 1, 0, 0, 0, 0,            32'h900, 1, 3, 2);
        vecs[28] = mk(1, 32'hAAA, 0, 1, 3, 2, 32'h100,      32'h100, 1, 3, 2);
        vecs[29] = mk(0, 0,       1, 0, 0, 0, 0,            32'h700, 1, 2, 1);
        // back-to-back recovers, count 0 writes nothing, last one wins
        vecs[30] = mk(0, 0,       0, 1, 1, 0, 32'hDEAD,     32'h50,  0, 1, 0);
        vecs[31] = mk(0, 0,       0, 1, 0, 4, 32'hBEEF,     32'hBEEF, 1, 0, 4);
        vecs[32] = mk(0, 0,       1, 1, 2, 2, 32'h123,      32'h123, 1, 2, 2);
        vecs[33] = mk(1, 32'h555, 1, 0, 0, 0, 0,            32'h555, 1, 2, 2);

        // reset state
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check_state(-1, 32'h0, 1'b0, 2'd0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            apply_vec(vecs[i]);
            check_state(i, vecs[i].exp_top, vecs[i].exp_valid, vecs[i].exp_ptr, vecs[i].exp_cnt);
        end

        // inputs must not reach outputs before the clock edge
        push = 1'b1; push_addr = 32'hFFFF; pop = 1'b1;
        recover = 1'b1; recover_ptr = 2'd1; recover_count = 3'd1; recover_top_addr = 32'h77;
        #2;
        check_state(100, 32'h555, 1'b1, 2'd2, 3'd2);
        drive_idle();

        // asynchronous reset mid-sequence discards everything
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_state(101, 32'h0, 1'b0, 2'd0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push = 1'b1; push_addr = 32'h100;
        @(posedge clk);
        #1;
        drive_idle();
        check_state(102, 32'h100, 1'b1, 2'd1, 3'd1);
        // the entries below the new top are cleared, not stale
        pop = 1'b1;
        @(posedge clk);
        #1;
        drive_idle();
        check_state(103, 32'h0, 1'b0, 2'd0, 3'd0);

        // report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
